rca_pipe: RTL

RCA_PIPE -- requirements
Module: rca_pipe

---
 rtl/rca_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/rca_pipe.sv
// rca_pipe: pipelined ripple-carry adder. Stage k adds one CW-bit chunk,
// taking its carry from the register behind stage k-1. Upper operand chunks
// ride along the pipeline until their stage consumes them. Finished sum
// chunks accumulate so that every chunk of an operation leaves together.
// The final stage feeds the registered outputs directly, so latency is STAGES.
module rca_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int SAT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);
    localparam int CW = WIDTH / STAGES;

    // Signals produced by the last stage's adder, before the output register
    logic [WIDTH-1:0] fin_raw;
    logic             fin_co;
    logic             fin_ovf;
    logic             fin_a_msb;
    logic             fin_valid;
    logic [WIDTH-1:0] fin_sum;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        logic [CW-1:0] ca;
        logic [CW-1:0] cb;
        logic          cin;
        logic          vin;
        logic [CW:0]   add;

        // Chunk k comes straight from the ports for stage 0, otherwise it is
        // the lowest operand chunk still held by the previous stage register.
        if (k == 0) begin : src_g
            assign ca  = a[CW-1:0];
            assign cb  = b[CW-1:0];
            assign cin = ci;
            assign vin = in_valid;
        end else begin : src_g
            assign ca  = stg[k-1].reg_g.a_hi[CW-1:0];
            assign cb  = stg[k-1].reg_g.b_hi[CW-1:0];
            assign cin = stg[k-1].reg_g.carry;
            assign vin = stg[k-1].reg_g.valid;
        end

        // Carry chain limited to one chunk
        assign add = {1'b0, ca} + {1'b0, cb} + {{CW{1'b0}}, cin};

        if (k < STAGES - 1) begin : reg_g
            // Operand bits not yet consumed, and sum bits already produced
            localparam int HW = (STAGES - 1 - k) * CW;
            localparam int LW = (k + 1) * CW;

            logic [HW-1:0] a_hi;
            logic [HW-1:0] b_hi;
            logic [HW-1:0] a_nxt;
            logic [HW-1:0] b_nxt;
            logic [LW-1:0] sum_lo;
            logic [LW-1:0] sum_nxt;
            logic          carry;
            logic          valid;

            if (k == 0) begin : nxt_g
                assign a_nxt   = a[WIDTH-1:CW];
                assign b_nxt   = b[WIDTH-1:CW];
                assign sum_nxt = add[CW-1:0];
            end else begin : nxt_g
                assign a_nxt   = stg[k-1].reg_g.a_hi[HW+CW-1:CW];
                assign b_nxt   = stg[k-1].reg_g.b_hi[HW+CW-1:CW];
                assign sum_nxt = {add[CW-1:0], stg[k-1].reg_g.sum_lo};
            end

            // Stage register: advances on en, cleared at once by rst
            // NOTE: sequential state uses non-blocking (<=) so every stage samples its
            // neighbour's old value on the same edge; blocking here would collapse the pipe.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_hi   <= '0;
                    b_hi   <= '0;
                    sum_lo <= '0;
                    carry  <= 1'b0;
                    valid  <= 1'b0;
                end else if (en) begin
                    a_hi   <= a_nxt;
                    b_hi   <= b_nxt;
                    sum_lo <= sum_nxt;
                    carry  <= add[CW];
                    valid  <= vin;
                end
            end
        end else begin : fin_g
            if (k == 0) begin : raw_g
                assign fin_raw = add[CW-1:0];
            end else begin : raw_g
                assign fin_raw = {add[CW-1:0], stg[k-1].reg_g.sum_lo};
            end
            // The top chunk holds both operand sign bits and the raw sum sign bit
            assign fin_co    = add[CW];
            assign fin_a_msb = ca[CW-1];
            assign fin_ovf   = (ca[CW-1] == cb[CW-1]) && (add[CW-1] != ca[CW-1]);
            assign fin_valid = vin;
        end
    end

    // Optional clamp to the signed range when the raw sum overflowed
    always_comb begin
        // NOTE: default assignment first so no path leaves fin_sum unassigned (no latch).
        fin_sum = fin_raw;
        if ((SAT != 0) && fin_ovf) begin
            fin_sum = fin_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // Output register: results update only for valid operations, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
        end else if (en) begin
            out_valid <= fin_valid;
            if (fin_valid) begin
                s   <= fin_sum;
                co  <= fin_co;
                ovf <= fin_ovf;
            end
        end
    end

endmodule
